// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the MEM stage.
// Turns a load or store request into a single registered bus transaction.
// Misaligned accesses are rejected with a one-cycle pulse.
// A bus that never answers is abandoned after TIMEOUT_CYCLES wait cycles.
// The pipeline is frozen while a transaction is outstanding.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_funct,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        misalign,
    output logic        timeout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Access size is funct[1:0]: 00 byte, 01 half, anything else is a word.
    function automatic logic calc_misaligned(input logic [2:0] funct, input logic [1:0] off);
        logic mis;
        case (funct[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] calc_be(input logic [2:0] funct, input logic [1:0] off);
        logic [3:0] be;
        case (funct[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [2:0] funct, input logic [31:0] wdata);
        logic [31:0] wd;
        case (funct[1:0])
            2'b00:   wd = {4{wdata[7:0]}};
            2'b01:   wd = {2{wdata[15:0]}};
            default: wd = wdata;
        endcase
        return wd;
    endfunction

    // Pick the addressed lane out of the read word and extend it to 32 bits.
    function automatic logic [31:0] calc_load(input logic [2:0] funct, input logic [1:0] off,
                                              input logic [31:0] rdata);
        logic [31:0] shifted;
        logic [15:0] half;
        logic [31:0] res;
        shifted = rdata >> {off, 3'b000};
        half    = off[1] ? rdata[31:16] : rdata[15:0];
        case (funct)
            3'b000:  res = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  res = {{16{half[15]}}, half};
            3'b100:  res = {24'h00_0000, shifted[7:0]};
            3'b101:  res = {16'h0000, half};
            default: res = rdata;
        endcase
        return res;
    endfunction

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             bus_req_q,   bus_req_d;
    logic             bus_we_q,    bus_we_d;
    logic [31:0]      bus_addr_q,  bus_addr_d;
    logic [3:0]       bus_be_q,    bus_be_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;
    logic [31:0]      load_data_q, load_data_d;
    logic             misalign_q,  misalign_d;
    logic             timeout_q,   timeout_d;
    logic [2:0]       funct_q,     funct_d;
    logic [1:0]       off_q,       off_d;

    logic req_s;
    logic misal_s;

    assign req_s   = mem_read | mem_write;
    assign misal_s = calc_misaligned(mem_funct, mem_addr[1:0]);

    // Freeze the pipeline from the request cycle until the bus answers or times out.
    assign stall = ((state_q == ST_IDLE) && req_s && !misal_s) || (state_q == ST_BUSY);

    // Next-state and next-output logic for the access FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        load_data_d = load_data_q;
        funct_d     = funct_q;
        off_d       = off_q;
        misalign_d  = 1'b0;
        timeout_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s && !misal_s) begin
                    state_d     = ST_BUSY;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    // A simultaneous read and write is served as a read.
                    bus_we_d    = ~mem_read;
                    bus_addr_d  = {mem_addr[31:2], 2'b00};
                    bus_be_d    = calc_be(mem_funct, mem_addr[1:0]);
                    bus_wdata_d = calc_wdata(mem_funct, mem_wdata);
                    funct_d     = mem_funct;
                    off_d       = mem_addr[1:0];
                end else if (req_s) begin
                    misalign_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (bus_ready) begin
                    state_d   = ST_DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        load_data_d = calc_load(funct_q, off_q, bus_rdata);
                    end else begin
                        load_data_d = load_data_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_DONE;
                    bus_req_d   = 1'b0;
                    timeout_d   = 1'b1;
                    load_data_d = 32'h0000_0000;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // One unstalled cycle lets the pipeline advance past this access.
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0000_0000;
            load_data_q <= 32'h0000_0000;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
            funct_q     <= 3'b000;
            off_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            load_data_q <= load_data_d;
            misalign_q  <= misalign_d;
            timeout_q   <= timeout_d;
            funct_q     <= funct_d;
            off_q       <= off_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign load_data = load_data_q;
    assign misalign  = misalign_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed vector table,
// hand-written multi-cycle sequences and randomized transactions
// checked against a transaction-level reference model.
module tb_dmem_access_ctrl;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_funct;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic [31:0] load_data;
    logic        stall;
    logic        misalign;
    logic        timeout;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .mem_funct(mem_funct),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .load_data(load_data), .stall(stall), .misalign(misalign), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  funct;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;     // BUSY cycle index in which ready is given
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic        we;
        logic [31:0] load;
        logic        mis;
        logic        to;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] model_load = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rdt, input int dly,
                                input logic [3:0] be, input logic [31:0] bwd, input logic we,
                                input logic [31:0] ld, input logic mis, input logic to);
        vec_t v;
        v.rd = rd; v.wr = wr; v.funct = f; v.addr = a; v.wdata = wd; v.rdata = rdt;
        v.delay = dly; v.be = be; v.bwdata = bwd; v.we = we; v.load = ld; v.mis = mis; v.to = to;
        return v;
    endfunction

    // Reference model: expectations from access size, offset and arithmetic.
    function automatic vec_t model(input logic rd, input logic wr, input logic [2:0] f,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] rdt, input int dly, input logic [31:0] prev);
        vec_t v;
        int unsigned sz;
        int unsigned off;
        logic [31:0] lane;
        logic [31:0] val;
        sz  = (f[1:0] == 2'b00) ? 1 : ((f[1:0] == 2'b01) ? 2 : 4);
        off = a % 4;
        v = mk(rd, wr, f, a, wd, rdt, dly, 4'h0, 32'h0, 1'b0, prev, 1'b0, 1'b0);
        v.mis = (a % sz) != 0;
        v.we  = !rd;
        v.be  = 4'(((1 << sz) - 1) << off);
        if (sz == 1)      v.bwdata = (wd & 32'hFF) * 32'h0101_0101;
        else if (sz == 2) v.bwdata = (wd & 32'hFFFF) * 32'h0001_0001;
        else              v.bwdata = wd;
        lane = rdt >> (8 * off);
        if (sz == 4) begin
            val = rdt;
        end else if (sz == 1) begin
            val = lane & 32'hFF;
            if (!f[2] && val >= 32'd128) val = val - 32'd256;
        end else begin
            val = lane & 32'hFFFF;
            if (!f[2] && val >= 32'd32768) val = val - 32'd65536;
        end
        v.to = !v.mis && (dly >= T);
        if (v.mis)     v.load = prev;
        else if (v.to) v.load = 32'h0;
        else if (rd)   v.load = val;
        else           v.load = prev;
        return v;
    endfunction

    task automatic idle_inputs();
        mem_read = 1'b0; mem_write = 1'b0; mem_funct = 3'b000;
        mem_addr = 32'h0; mem_wdata = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;
    endtask

    // Runs one access from IDLE and checks every cycle; returns in IDLE.
    task automatic run_txn(input vec_t v, input string tag);
        int nb;
        mem_read = v.rd; mem_write = v.wr; mem_funct = v.funct;
        mem_addr = v.addr; mem_wdata = v.wdata; bus_rdata = v.rdata;
        bus_ready = 1'b1;   // ignored while IDLE
        #1;
        chk({tag, " stall_req"}, 32'(stall), 32'(!v.mis));
        if (v.mis) begin
            @(posedge clk); #1;
            mem_read = 1'b0; mem_write = 1'b0; bus_ready = 1'b0;
            chk({tag, " mis_pulse"}, 32'(misalign), 32'h1);
            chk({tag, " mis_noreq"}, 32'(bus_req), 32'h0);
            chk({tag, " mis_stall"}, 32'(stall), 32'h0);
            @(posedge clk); #1;
            chk({tag, " mis_end"}, 32'(misalign), 32'h0);
            chk({tag, " mis_noreq2"}, 32'(bus_req), 32'h0);
            chk({tag, " mis_load"}, load_data, v.load);
        end else begin
            nb = v.to ? T : v.delay + 1;
            for (int i = 0; i < nb; i++) begin
                @(posedge clk); #1;
                chk({tag, " busy_req"}, 32'(bus_req), 32'h1);
                chk({tag, " busy_addr"}, bus_addr, v.addr & 32'hFFFF_FFFC);
                chk({tag, " busy_be"}, 32'(bus_be), 32'(v.be));
                chk({tag, " busy_we"}, 32'(bus_we), 32'(v.we));
                chk({tag, " busy_wdata"}, bus_wdata, v.bwdata);
                chk({tag, " busy_stall"}, 32'(stall), 32'h1);
                chk({tag, " busy_to"}, 32'(timeout), 32'h0);
                bus_ready = (!v.to && i == v.delay);
            end
            @(posedge clk); #1;
            mem_read = 1'b0; mem_write = 1'b0;
            bus_ready = 1'b1;   // ignored in DONE
            bus_rdata = ~v.rdata;
            chk({tag, " done_req"}, 32'(bus_req), 32'h0);
            chk({tag, " done_stall"}, 32'(stall), 32'h0);
            chk({tag, " done_to"}, 32'(timeout), 32'(v.to));
            chk({tag, " done_load"}, load_data, v.load);
            @(posedge clk); #1;
            bus_ready = 1'b0;
            chk({tag, " idle_req"}, 32'(bus_req), 32'h0);
            chk({tag, " idle_to"}, 32'(timeout), 32'h0);
            chk({tag, " idle_load"}, load_data, v.load);
        end
        model_load = v.load;
    endtask

    vec_t tbl[13];
    vec_t rv;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst bus_req", 32'(bus_req), 32'h0);
        chk("rst bus_we", 32'(bus_we), 32'h0);
        chk("rst bus_addr", bus_addr, 32'h0);
        chk("rst bus_be", 32'(bus_be), 32'h0);
        chk("rst bus_wdata", bus_wdata, 32'h0);
        chk("rst load", load_data, 32'h0);
        chk("rst stall", 32'(stall), 32'h0);
        chk("rst mis", 32'(misalign), 32'h0);
        chk("rst to", 32'(timeout), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        //          rd    wr    f       addr          wdata         rdata         dly be       bwdata        we    load          mis   to
        tbl[0]  = mk(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_FF12, 1, 4'b1000, 32'h0,        1'b0, 32'hFFFF_FF80, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 32'h0,        0, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,         0, 4'b0000, 32'h0,        1'b0, 32'hFFFF_FF80, 1'b1, 1'b0);
        tbl[3]  = mk(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0,        32'hDEAD_BEEF, 99, 4'b1111, 32'h0,       1'b0, 32'h0,         1'b0, 1'b1);
        tbl[4]  = mk(1'b1, 1'b0, 3'b100, 32'h0000_0201, 32'h0,        32'h1234_8A56, 2, 4'b0010, 32'h0,        1'b0, 32'h0000_008A, 1'b0, 1'b0);
        tbl[5]  = mk(1'b1, 1'b0, 3'b001, 32'h0000_0012, 32'h0,        32'h9ABC_1234, 0, 4'b1100, 32'h0,        1'b0, 32'hFFFF_9ABC, 1'b0, 1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 3'b101, 32'h0000_0010, 32'h0,        32'h0000_F00D, 0, 4'b0011, 32'h0,        1'b0, 32'h0000_F00D, 1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, 3'b000, 32'h0000_0031, 32'hAABB_CC7E, 32'h0,        0, 4'b0010, 32'h7E7E_7E7E, 1'b1, 32'h0000_F00D, 1'b0, 1'b0);
        tbl[8]  = mk(1'b1, 1'b1, 3'b010, 32'h0000_0080, 32'h5555_5555, 32'h0123_4567, 3, 4'b1111, 32'h5555_5555, 1'b0, 32'h0123_4567, 1'b0, 1'b0);
        tbl[9]  = mk(1'b1, 1'b0, 3'b011, 32'h0000_0042, 32'h0,        32'h0,         0, 4'b0000, 32'h0,        1'b0, 32'h0123_4567, 1'b1, 1'b0);
        tbl[10] = mk(1'b0, 1'b1, 3'b111, 32'h0000_0044, 32'hCAFE_F00D, 32'h0,        1, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'h0123_4567, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 1'b1, 3'b001, 32'h0000_0023, 32'h0,        32'h0,         0, 4'b0000, 32'h0,        1'b0, 32'h0123_4567, 1'b1, 1'b0);
        tbl[12] = mk(1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0,        32'h80FF_FF12, 0, 4'b0001, 32'h0,        1'b0, 32'h0000_0012, 1'b0, 1'b0);

        for (int i = 0; i < 13; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
        end

        // Back-to-back: read held across DONE with a new address.
        mem_read = 1'b1; mem_funct = 3'b010; mem_addr = 32'h0000_0300; bus_ready = 1'b0;
        #1;
        chk("b2b stall0", 32'(stall), 32'h1);
        @(posedge clk); #1;
        chk("b2b req1", 32'(bus_req), 32'h1);
        chk("b2b addr1", bus_addr, 32'h0000_0300);
        bus_ready = 1'b1; bus_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        bus_ready = 1'b0; mem_addr = 32'h0000_0304;
        #1;
        chk("b2b done_req", 32'(bus_req), 32'h0);
        chk("b2b done_stall", 32'(stall), 32'h0);
        chk("b2b done_load", load_data, 32'h1111_1111);
        @(posedge clk); #1;
        chk("b2b idle_req", 32'(bus_req), 32'h0);
        chk("b2b idle_stall", 32'(stall), 32'h1);
        @(posedge clk); #1;
        chk("b2b req2", 32'(bus_req), 32'h1);
        chk("b2b addr2", bus_addr, 32'h0000_0304);
        bus_ready = 1'b1; bus_rdata = 32'h2222_2222;
        @(posedge clk); #1;
        mem_read = 1'b0; bus_ready = 1'b0;
        chk("b2b done2_req", 32'(bus_req), 32'h0);
        chk("b2b done2_load", load_data, 32'h2222_2222);
        @(posedge clk); #1;

        // Reset in the middle of a store wait.
        mem_write = 1'b1; mem_funct = 3'b010; mem_addr = 32'h0000_0500; mem_wdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rstmid busy_req", 32'(bus_req), 32'h1);
        end
        reset = 1'b1; mem_write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rstmid req", 32'(bus_req), 32'h0);
        chk("rstmid we", 32'(bus_we), 32'h0);
        chk("rstmid addr", bus_addr, 32'h0);
        chk("rstmid be", 32'(bus_be), 32'h0);
        chk("rstmid wdata", bus_wdata, 32'h0);
        chk("rstmid load", load_data, 32'h0);
        chk("rstmid stall", 32'(stall), 32'h0);
        bus_ready = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        chk("rstmid late_ready_req", 32'(bus_req), 32'h0);
        chk("rstmid late_ready_load", load_data, 32'h0);
        chk("rstmid late_ready_stall", 32'(stall), 32'h0);
        model_load = 32'h0;
        idle_inputs();

        // Randomized transactions against the reference model.
        for (int k = 0; k < 150; k++) begin
            int unsigned op;
            int dly;
            op  = $urandom_range(1, 3);
            dly = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 2, T + 3) : $urandom_range(0, 4);
            rv = model(op[0], op[1], 3'($urandom_range(0, 7)), $urandom & 32'h0000_FFFF,
                       $urandom, $urandom, dly, model_load);
            run_txn(rv, $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum BUSY cycles waited for bus_ready before abort.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port mem_read  input  1  MEM-stage load request.
REQ-005 The block SHALL have port mem_write  input  1  MEM-stage store request.
REQ-006 The block SHALL have port mem_funct  input  3  access width: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-007 The block SHALL have port mem_addr  input  32  byte address (MEM-stage ALU result).
REQ-008 The block SHALL have port mem_wdata  input  32  store data, right-aligned.
REQ-009 The block SHALL have port bus_req  output  1  data bus request, registered.
REQ-010 The block SHALL have port bus_we  output  1  1 = write, registered.
REQ-011 The block SHALL have port bus_addr  output  32  word address, mem_addr with bits [1:0] forced to 0, registered.
REQ-012 The block SHALL have port bus_be  output  4  byte enables, registered.
REQ-013 The block SHALL have port bus_wdata  output  32  lane-replicated store data, registered.
REQ-014 The block SHALL have port bus_ready  input  1  bus completion strobe, valid only while bus_req=1.
REQ-015 The block SHALL have port bus_rdata  input  32  read word, valid with bus_ready.
REQ-016 The block SHALL have port load_data  output  32  extended load result, registered.
REQ-017 The block SHALL have port stall  output  1  freeze request to all pipeline registers up to and including EX/MEM.
REQ-018 The block SHALL have port misalign  output  1  one-cycle misaligned-access pulse.
REQ-019 The block SHALL have port timeout  output  1  one-cycle bus-timeout pulse.

Function
REQ-020 States SHALL be IDLE, BUSY, DONE; stall = (IDLE and aligned access requested) or BUSY, combinational.
REQ-021 Access requested = mem_read or mem_write; if both are 1, read SHALL take precedence and bus_we=0.
REQ-022 Misaligned = half with addr[0]=1, or word with addr[1:0]!=00; funct 011/110/111 SHALL be treated as word.
REQ-023 IDLE, aligned access: next edge SHALL load bus_addr/be/we/wdata, set bus_req=1, enter BUSY, clear wait counter.
REQ-024 IDLE, misaligned access: next cycle misalign=1 for exactly one cycle, no bus_req, stall=0, stay IDLE.
REQ-025 BUSY: bus_req and all bus outputs SHALL hold stable until bus_ready=1 is sampled.
REQ-026 BUSY with bus_ready=1: next edge bus_req=0, load_data updated (reads only), enter DONE.
REQ-027 BUSY without bus_ready: counter increments; when counter reaches TIMEOUT_CYCLES-1 without ready, next edge bus_req=0, timeout=1 one cycle, load_data=0, enter DONE.
REQ-028 DONE: stall=0 for exactly one cycle so the pipeline advances; next state IDLE unconditionally; request inputs ignored in DONE.
REQ-029 bus_be: byte = 0001 shifted by addr[1:0]; half = 0011 shifted by addr[1]*2; word = 1111.
REQ-030 bus_wdata: byte = wdata[7:0] replicated x4; half = wdata[15:0] replicated x2; word = wdata.
REQ-031 load_data: selected lane right-aligned; sign-extended for 000/001, zero-extended for 100/101, full word for 010.
REQ-032 bus_ready outside BUSY SHALL be ignored; writes SHALL leave load_data unchanged.

Reset
REQ-033 reset=1 at a rising edge SHALL force IDLE, counter=0, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, load_data=0, misalign=0, timeout=0, including mid-BUSY (bus_req drops at that edge).

Verification
REQ-034 Load byte: mem_read=1, funct=000, addr=0x103, ready after 2 cycles, rdata=0x80FF_FF12 -> bus_addr=0x100, be=1000, stall high 3 cycles, load_data=0xFFFF_FF80.
REQ-035 Store half: mem_write=1, funct=001, addr=0x22, wdata=0x1234_ABCD, ready immediately -> be=1100, bus_wdata=0xABCD_ABCD, bus_we=1, stall high 2 cycles.
REQ-036 Misaligned word: mem_read=1, funct=010, addr=0x6 -> misalign one pulse, bus_req never asserted, stall=0.
REQ-037 Timeout: aligned read, bus_ready held 0 -> bus_req high exactly TIMEOUT_CYCLES cycles, timeout pulse, load_data=0, DONE then IDLE.
REQ-038 Reset mid-BUSY: assert reset during wait -> next edge bus_req=0, stall=0, all outputs zero; later ready pulse ignored.
REQ-039 Back-to-back: mem_read held 1 across DONE with new addr -> exactly one DONE gap cycle, second request issued from IDLE.
